snake_move_sched: RTL
=====================

Name: snake_move_sched

Overview:
- Movement controller for the snake game on the 6x6 dot matrix.
- Synchronizes and debounces the four direction buttons, and arbitrates simultaneous presses.
- Rejects 180-degree reversals.
- Generates the periodic game step and advances the head coordinate with wrap-around.
- Downstream body/apple logic and the row/col scan driver consume dir, head_x, head_y and the step strobe.

Parameters:
- CLK_HZ, 12_000_000, input clock frequency; informational, used only to derive the defaults below.
- DEBOUNCE_CYCLES, 120_000, consecutive stable cycles required before a button level is accepted (10 ms).
- STEP_CYCLES, 3_000_000, clock cycles per game step (250 ms).
- GRID, 6, matrix width and height.
- START_X, 0, head column after reset.
- START_Y, 0, head row after reset.
- CW, $clog2(GRID), coordinate width (3 for GRID=6).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  1 = step timer advances; 0 = game paused
- btn_up  in  1  raw asynchronous button, active-high
- btn_right  in  1  raw asynchronous button, active-high
- btn_down  in  1  raw asynchronous button, active-high
- btn_left  in  1  raw asynchronous button, active-high
- dir  out  2  committed direction: 0 up, 1 right, 2 down, 3 left
- head_x  out  CW  head column, 0..GRID-1
- head_y  out  CW  head row, 0..GRID-1 (0 = top)
- step  out  1  one-cycle pulse, high in the cycle the new head/dir are first visible
- press  out  4  one-cycle debounced press events {left,down,right,up}, for a sound/attract block

Behaviour:
- Reset values (rst sampled high on a clk edge, all state):
  - dir=1, head_x=START_X, head_y=START_Y, step=0, press=0.
  - Debounced levels=0, debounce counters=0, step counter=0, pending invalid.
  - Reset dominates every other input in the same cycle.
  - A reset mid-debounce discards the partial count.
- Synchronizer: 2 flops per button; all later logic uses only the synchronized level.
- Debounce, per button:
  - Counter counts while the sync level differs from the debounced level.
  - The counter clears whenever they are equal.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - A rising edge of the debounced level gives press[i]=1 for exactly one cycle.
  - Release produces no event.
  - Latency from raw edge to press: 2 + DEBOUNCE_CYCLES cycles.
- Request arbitration, each cycle with any press bit set:
  - A candidate is valid if its code is not equal to dir and not equal to dir^2 (the reverse). Comparison is always against the committed dir, never the pending value.
  - Among valid candidates, priority is up > right > down > left.
  - The winner is written to pending and pending is set valid; a later valid press before the step overwrites it.
  - No valid candidate: pending unchanged.
- Step timer:
  - run=1: counter increments; at STEP_CYCLES-1 it wraps to 0 and a step event fires.
  - run=0: counter holds, no step; presses and pending are still accepted.
- Step event, at the wrap edge:
  - dir <= pending if valid, else dir; pending cleared.
  - Head moves one cell in the new dir: up y-1, down y+1, left x-1, right x+1.
  - Wrap-around: y=0 up -> GRID-1; y=GRID-1 down -> 0; x=0 left -> GRID-1; x=GRID-1 right -> 0.
  - step=1 for the following single cycle, coinciding with the updated dir/head.
  - A press arriving in the same cycle as the step event is arbitrated against the old dir and lands in pending for the next step, since the step consumes the prior pending.
- Step period: exactly STEP_CYCLES cycles while run=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=16, GRID=6, START=(0,0)):
- Reset, run=1, no buttons:
  - Requires dir=1, head=(0,0), step=0 after reset.
  - First step 16 cycles after reset release gives head=(1,0); steps recur every 16 cycles.
- btn_up high for 2 cycles:
  - No press and no dir change.
  - btn_up held 12 cycles: press[0] once, 6 cycles after the rising edge.
  - Next step gives dir=0 and head_y wrapping 0->5.
- Reversal, dir=1: btn_left pressed -> ignored; dir stays 1 and head_x keeps incrementing.
- Simultaneous and overwrite, dir=1:
  - btn_up and btn_down pressed together -> next step dir=0.
  - Then press right, then down before the step -> dir=2 at the step.
- Wrap, dir=1: run 6 steps from x=0 -> head_x sequence 1,2,3,4,5,0.
- Pause and reset:
  - run=0 for 40 cycles -> no step, head frozen; a press still updates pending.
  - run=1 -> first step exactly 16 cycles of run later, from the held count, with the pending dir applied.
  - rst asserted mid-debounce -> all outputs back to reset values; no press emitted afterwards.

Source files
------------

// File: rtl/snake_move_sched.sv
`timescale 1ns/1ps
// snake_move_sched: movement controller for the 6x6 snake game.
// Synchronizes and debounces the four direction buttons, arbitrates presses
// into a pending direction (rejecting reversals), and on every game step
// commits the pending direction and advances the head with wrap-around.
module snake_move_sched #(
  parameter int CLK_HZ          = 12_000_000,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int STEP_CYCLES     = CLK_HZ / 4,
  parameter int GRID            = 6,
  parameter int START_X         = 0,
  parameter int START_Y         = 0,
  parameter int CW              = $clog2(GRID)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          btn_up,
  input  logic          btn_right,
  input  logic          btn_down,
  input  logic          btn_left,
  output logic [1:0]    dir,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic          step,
  output logic [3:0]    press
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] GRID_LAST = CW'(GRID - 1);
  localparam logic [CW-1:0] X_INIT    = CW'(START_X);
  localparam logic [CW-1:0] Y_INIT    = CW'(START_Y);

  // Direction codes double as press bit indices, so the reverse is code ^ 2.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  logic [3:0]    btn_raw;
  logic [3:0]    sync_a;
  logic [3:0]    sync_b;
  logic [3:0]    db_level;
  logic [DW-1:0] db_cnt [4];
  logic [3:0]    press_q;
  logic [SW-1:0] step_cnt;
  logic          step_event;
  logic          step_q;
  dir_t          dir_q;
  dir_t          pend_dir;
  logic          pend_valid;
  dir_t          next_dir;
  dir_t          cand_dir;
  logic          cand_found;
  logic [CW-1:0] hx;
  logic [CW-1:0] hy;
  logic [CW-1:0] nx;
  logic [CW-1:0] ny;

  assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

  // Two-flop synchronizer per button; nothing downstream looks at btn_raw.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: accept a new level after it has differed long enough, and flag rising edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= '0;
      press_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      press_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEB_LAST) begin
          db_cnt[i]   <= '0;
          db_level[i] <= ~db_level[i];
          press_q[i]  <= ~db_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pick the highest-priority press that is neither the current direction nor its reverse.
  always_comb begin
    cand_found = 1'b0;
    cand_dir   = DIR_UP;
    for (int i = 3; i >= 0; i--) begin
      if (press_q[i] && (2'(i) != dir_q) && (2'(i) != (dir_q ^ 2'd2))) begin
        cand_found = 1'b1;
        cand_dir   = dir_t'(2'(i));
      end
    end
  end

  // Game step timer; the step fires on the edge where the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (run) begin
      step_cnt <= step_event ? '0 : step_cnt + 1'b1;
    end
  end

  assign step_event = run && (step_cnt == STEP_LAST);
  assign next_dir   = pend_valid ? pend_dir : dir_q;

  // Next head position one cell along the direction being committed, wrapping at the edges.
  always_comb begin
    nx = hx;
    ny = hy;
    case (next_dir)
      DIR_UP:    ny = (hy == '0) ? GRID_LAST : hy - 1'b1;
      DIR_DOWN:  ny = (hy == GRID_LAST) ? '0 : hy + 1'b1;
      DIR_LEFT:  nx = (hx == '0) ? GRID_LAST : hx - 1'b1;
      DIR_RIGHT: nx = (hx == GRID_LAST) ? '0 : hx + 1'b1;
    endcase
  end

  // Commit direction and head on a step; a press in the same cycle lands in pending for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= DIR_RIGHT;
      hx         <= X_INIT;
      hy         <= Y_INIT;
      pend_dir   <= DIR_UP;
      pend_valid <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      step_q <= step_event;
      if (step_event) begin
        dir_q      <= next_dir;
        hx         <= nx;
        hy         <= ny;
        pend_valid <= 1'b0;
      end
      if (cand_found) begin
        pend_dir   <= cand_dir;
        pend_valid <= 1'b1;
      end
    end
  end

  assign dir    = dir_q;
  assign head_x = hx;
  assign head_y = hy;
  assign step   = step_q;
  assign press  = press_q;

endmodule
